// File: rtl/prio_arb_pkg.sv
// Shared encodings for the priority / round-robin arbiter: FSM states and
// arbitration mode values.
package prio_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } arb_mode_e;

endpackage

// File: rtl/prio_enc_msb.sv
// Combinational MSB-first priority encoder: idx is the highest set bit of req,
// any flags that at least one bit is set.
module prio_enc_msb #(
    parameter  int N = 16,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (req[k]) begin
                idx = W'(k);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_rr_arbiter.sv
// N-way arbiter with a registered, sticky grant: fixed MSB priority or
// descending round-robin starting at ptr, with back-to-back grants on transfer.
module prio_rr_arbiter
    import prio_arb_pkg::*;
#(
    parameter  int N = 16,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic         mode_i,
    input  logic         gnt_ready_i,
    output logic         gnt_valid_o,
    output logic [W-1:0] gnt_idx_o,
    output logic [N-1:0] gnt_onehot_o
);

    localparam logic [W-1:0] LAST_IDX = W'(N - 1);
    localparam logic [W:0]   N_WIDE   = (W + 1)'(N);

    arb_state_e   state;
    arb_mode_e    mode;
    logic [W-1:0] ptr;

    logic         transfer;
    logic         arbitrate;
    logic [W-1:0] ptr_dec;
    logic [W-1:0] ptr_eff;
    logic [W-1:0] base;
    logic [W-1:0] off;
    logic [2*N-1:0] req_dbl_shift;
    logic [N-1:0] req_rot;
    logic [W-1:0] enc_idx;
    logic         enc_any;
    logic [W:0]   win_sum;
    logic [W-1:0] win_idx;
    logic [N-1:0] win_onehot;

    assign mode        = arb_mode_e'(mode_i);
    assign gnt_valid_o = (state == GRANT);
    assign transfer    = gnt_valid_o & gnt_ready_i;
    assign arbitrate   = (state == IDLE) | transfer;

    // Serving index k leaves k at lowest priority: the new top is k-1 (mod N).
    assign ptr_dec = (gnt_idx_o == '0) ? LAST_IDX : gnt_idx_o - W'(1);
    assign ptr_eff = (transfer && mode == MODE_RR) ? ptr_dec : ptr;

    // Fixed priority is round-robin with the top pinned at N-1.
    assign base = (mode == MODE_RR) ? ptr_eff : LAST_IDX;

    // Rotate so that req_i[base] lands on the MSB: req_rot[j] = req_i[(j+off) mod N].
    assign off           = (base == LAST_IDX) ? '0 : base + W'(1);
    assign req_dbl_shift = {req_i, req_i} >> off;
    assign req_rot       = req_dbl_shift[N-1:0];

    prio_enc_msb #(
        .N (N)
    ) u_enc (
        .req (req_rot),
        .idx (enc_idx),
        .any (enc_any)
    );

    assign win_sum    = {1'b0, enc_idx} + {1'b0, off};
    assign win_idx    = (win_sum >= N_WIDE) ? W'(win_sum - N_WIDE) : win_sum[W-1:0];
    assign win_onehot = {{(N-1){1'b0}}, 1'b1} << win_idx;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= LAST_IDX;
            gnt_idx_o    <= '0;
            gnt_onehot_o <= '0;
        end else begin
            if (transfer && mode == MODE_RR) begin
                ptr <= ptr_dec;
            end
            // Without arbitration (GRANT, not accepted) the grant is held as-is.
            if (arbitrate) begin
                if (enc_any) begin
                    state        <= GRANT;
                    gnt_idx_o    <= win_idx;
                    gnt_onehot_o <= win_onehot;
                end else begin
                    state        <= IDLE;
                    gnt_idx_o    <= '0;
                    gnt_onehot_o <= '0;
                end
            end
        end
    end

endmodule
